uart_tx: RTL and testbench

//   Serialises parallel bytes onto a UART TXD line (8N1 by default; parity and stop bits configurable).

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: parity encodings, transmitter FSM states and
// bit-period helpers, common to the transmitter and the receiver.
package uart_tx_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  // Payload is zero-extended to 8 bits; the padding does not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    logic xor_s;
    xor_s = ^data;
    case (mode)
      PARITY_ODD:  return ~xor_s;
      PARITY_EVEN: return xor_s;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake between an upstream producer and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Divide-by-CLKS_PER_BIT counter; tick marks the last cycle of each bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_r;

  // Bit-period counter, held at zero while cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear || (count_r == LAST_COUNT)) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tick = !clear && (count_r == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts bytes over a valid/ready handshake and serialises them
// onto txd as start, LSB-first data, optional parity and stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    up,
  output logic        txd,
  output logic        busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [1:0] PARITY_MODE = 2'(PARITY);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]           state_r;
  logic [2:0]           state_s;
  logic [2:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_r;
  logic                 txd_r;
  logic                 busy_r;
  logic                 in_ready_r;
  logic                 handshake_s;
  logic                 tick_s;

  assign handshake_s = up.in_valid && in_ready_r;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state_r == ST_IDLE),
    .tick  (tick_s)
  );

  // Next-state logic; every state boundary coincides with a baud tick
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) state_s = ST_START;
        else             state_s = ST_IDLE;
      end
      ST_START: begin
        if (tick_s) state_s = ST_DATA;
        else        state_s = ST_START;
      end
      ST_DATA: begin
        if (tick_s && (bit_cnt_r == LAST_DATA)) state_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
        else                                    state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (tick_s) state_s = ST_STOP;
        else        state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (tick_s && (bit_cnt_r == LAST_STOP)) state_s = ST_IDLE;
        else                                    state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; txd follows state_r one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= '0;
      parity_r   <= 1'b0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);

      if (handshake_s) begin
        shift_r  <= DATA_BITS'(up.in_data);
        parity_r <= parity_bit(8'(up.in_data), PARITY_MODE);
      end else if ((state_r == ST_DATA) && tick_s) begin
        shift_r <= shift_r >> 1;
      end

      if (state_s != state_r) begin
        bit_cnt_r <= 3'd0;
      end else if (tick_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end

      case (state_r)
        ST_START:  txd_r <= 1'b0;
        ST_DATA:   txd_r <= shift_r[0];
        ST_PARITY: txd_r <= parity_r;
        ST_STOP:   txd_r <= 1'b1;
        default:   txd_r <= 1'b1;
      endcase
    end
  end

  assign up.in_ready = in_ready_r;
  assign txd         = txd_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, even, odd at 16 clks/bit, and defaults).
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [3:0] valid_v;
  logic [7:0] data_a [4];
  wire  [3:0] txd_v;
  wire  [3:0] busy_v;
  wire  [3:0] rdy_v;
  int         checks;
  int         errors;
  int         cyc;
  int         hs_cyc;
  int         first_hs;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(8)) if3 ();

  assign if0.in_valid = valid_v[0];
  assign if1.in_valid = valid_v[1];
  assign if2.in_valid = valid_v[2];
  assign if3.in_valid = valid_v[3];
  assign if0.in_data  = data_a[0];
  assign if1.in_data  = data_a[1];
  assign if2.in_data  = data_a[2];
  assign if3.in_data  = data_a[3];
  assign rdy_v = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

  uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .up(if0), .txd(txd_v[0]), .busy(busy_v[0]));
  uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .up(if1), .txd(txd_v[1]), .busy(busy_v[1]));
  uart_tx #(.CLOCK_FREQUENCY(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .up(if2), .txd(txd_v[2]), .busy(busy_v[2]));
  uart_tx u_dflt (
    .clk(clk), .rst(rst), .up(if3), .txd(txd_v[3]), .busy(busy_v[3]));

  // Free-running clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends one byte on instance idx and checks every bit's level at its first and last cycle.
  task automatic send_frame(input int idx, input logic [7:0] b, input bit has_par, input logic pbit,
                            input int cpb, input bit hold, input logic [7:0] next_b, input string tag);
    logic exp_bits [11];
    int   nb;
    int   t;
    nb = has_par ? 11 : 10;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    exp_bits[9]  = has_par ? pbit : 1'b1;
    exp_bits[10] = 1'b1;
    data_a[idx]  = b;
    valid_v[idx] = 1'b1;
    t = 0;
    while ((rdy_v[idx] !== 1'b1) && (t < 20)) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_ready_wait"}, 32'(t < 20), 32'd1);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    if (hold) begin
      data_a[idx] = next_b;
    end else begin
      valid_v[idx] = 1'b0;
      data_a[idx]  = ~b;
    end
    check({tag, "_txd_latency"}, 32'(txd_v[idx]), 32'd1);
    check({tag, "_busy_hs"}, 32'(busy_v[idx]), 32'd1);
    check({tag, "_rdy_hs"}, 32'(rdy_v[idx]), 32'd0);
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < cpb; c++) begin
        @(posedge clk);
        #1;
        if ((c == 0) || (c == cpb - 1))
          check($sformatf("%s_b%0d_c%0d", tag, k, c), 32'(txd_v[idx]), 32'(exp_bits[k]));
        if (c == 0)
          check($sformatf("%s_rdy_b%0d", tag, k), 32'(rdy_v[idx]), 32'd0);
        if ((k == nb - 1) && (c == cpb - 2))
          check({tag, "_rdy_early"}, 32'(rdy_v[idx]), 32'd0);
        if ((k == nb - 1) && (c == cpb - 1)) begin
          check({tag, "_rdy_end"}, 32'(rdy_v[idx]), 32'd1);
          check({tag, "_busy_end"}, 32'(busy_v[idx]), 32'd0);
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    rst     = 1'b1;
    valid_v = 4'b0000;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_txd_%0d", i), 32'(txd_v[0]), 32'd1);
      check($sformatf("rst_rdy_%0d", i), 32'(rdy_v[0]), 32'd0);
      check($sformatf("rst_busy_%0d", i), 32'(busy_v[0]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rdy_after", 32'(rdy_v), 32'hF);
    check("rst_txd_after", 32'(txd_v), 32'hF);

    send_frame(0, 8'h55, 1'b0, 1'b0, 16, 1'b0, 8'h00, "n1_55");
    send_frame(1, 8'h07, 1'b1, 1'b1, 16, 1'b0, 8'h00, "even_07");
    send_frame(2, 8'h07, 1'b1, 1'b0, 16, 1'b0, 8'h00, "odd_07");

    send_frame(0, 8'hA5, 1'b0, 1'b0, 16, 1'b1, 8'h3C, "b2b_a5");
    first_hs = hs_cyc;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 16, 1'b0, 8'h00, "b2b_3c");
    check("b2b_hs_spacing", 32'(hs_cyc - first_hs), 32'd161);
    repeat (20) @(posedge clk);
    #1;
    check("b2b_no_extra_busy", 32'(busy_v[0]), 32'd0);

    data_a[0]  = 8'hF0;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check("midrst_txd_before", 32'(txd_v[0]), 32'd0);
    check("midrst_busy_before", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_txd", 32'(txd_v[0]), 32'd1);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_rdy", 32'(rdy_v[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_rdy_after", 32'(rdy_v[0]), 32'd1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 16, 1'b0, 8'h00, "post_rst_81");

    send_frame(3, 8'h00, 1'b0, 1'b0, 868, 1'b0, 8'h00, "dflt_00");
    send_frame(3, 8'hFF, 1'b0, 1'b0, 868, 1'b0, 8'h00, "dflt_ff");
    send_frame(3, 8'h5A, 1'b0, 1'b0, 868, 1'b0, 8'h00, "dflt_5a");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
